// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer controller:
// game states, display request modes and display value width.
package reaction_pkg;

    localparam int DISP_W        = 14;
    localparam int DEF_FAULT_VAL = 9999;
    localparam int DEF_MAX_MS    = 1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        TIMING = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DISP_BLANK = 2'd0,
        DISP_HI    = 2'd1,
        DISP_NUM   = 2'd2
    } disp_mode_e;

    // The millisecond time base only runs while a round is in progress.
    function automatic logic is_busy(input state_e s);
        return (s == WAIT) || (s == TIMING);
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Button pulses in, LED / display request out, between the debouncers,
// the controller and the seven-segment driver.
interface reaction_timer_ctrl_if;
    import reaction_pkg::*;

    logic              start;
    logic              stop;
    logic              clear;
    logic              led;
    disp_mode_e        disp_mode;
    logic [DISP_W-1:0] disp_value;
    logic              false_start;
    logic              busy;

    modport master (
        output start, stop, clear,
        input  led, disp_mode, disp_value, false_start, busy
    );

    modport slave (
        input  start, stop, clear,
        output led, disp_mode, disp_value, false_start, busy
    );
endinterface

// File: rtl/reaction_ms_tick.sv
// Millisecond prescaler: one-cycle tick on the last of every MS_TICKS
// enabled cycles; clr restarts the period from zero.
module reaction_ms_tick #(
    parameter int MS_TICKS = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int            CW   = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(MS_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Kept free of clr so the controller can derive clr from its next state.
    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer game sequencer: state machine, pre-LED delay and
// reaction-time count, with registered LED and display-request outputs.
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int MS_TICKS  = 100000,
    parameter int DELAY_MS  = 5000,
    parameter int MAX_MS    = DEF_MAX_MS,
    parameter int FAULT_VAL = DEF_FAULT_VAL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reaction_timer_ctrl_if.slave bus
);
    localparam int                DW        = $clog2(DELAY_MS + 1);
    localparam logic [DW-1:0]     DELAY_END = DW'(DELAY_MS);
    localparam logic [DISP_W-1:0] MAX_VAL   = DISP_W'(MAX_MS);
    localparam logic [DISP_W-1:0] FAULT     = DISP_W'(FAULT_VAL);

    state_e            state_q, state_d;
    logic [DW-1:0]     delay_q, delay_d, delay_inc;
    logic [DISP_W-1:0] count_q, count_d, count_inc;
    logic [DISP_W-1:0] disp_value_q, disp_value_d;
    disp_mode_e        disp_mode_q, disp_mode_d;
    logic              led_q, led_d;
    logic              false_start_q, false_start_d;
    logic              busy_q, busy_d;
    logic              ms_tick, tick_clr, tick_en;

    reaction_ms_tick #(
        .MS_TICKS (MS_TICKS)
    ) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (ms_tick)
    );

    assign delay_inc = delay_q + DW'(1);
    assign count_inc = count_q + DISP_W'(1);
    assign tick_en   = is_busy(state_q);
    // Every state change restarts the millisecond period.
    assign tick_clr  = (state_d != state_q);

    always_comb begin
        state_d       = state_q;
        delay_d       = delay_q;
        count_d       = count_q;
        disp_value_d  = disp_value_q;
        false_start_d = false_start_q;

        if (bus.clear) begin
            state_d       = IDLE;
            delay_d       = '0;
            count_d       = '0;
            disp_value_d  = '0;
            false_start_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // stop outranks start even though stop does nothing here
                    if (bus.start && !bus.stop) begin
                        state_d = WAIT;
                        delay_d = '0;
                        count_d = '0;
                    end
                end
                WAIT: begin
                    if (bus.stop) begin
                        state_d       = DONE;
                        disp_value_d  = FAULT;
                        false_start_d = 1'b1;
                    end else if (ms_tick) begin
                        delay_d = delay_inc;
                        if (delay_inc == DELAY_END) begin
                            state_d      = TIMING;
                            count_d      = '0;
                            disp_value_d = '0;
                        end
                    end
                end
                TIMING: begin
                    // A tick landing with stop is dropped: the shown time is as of stop.
                    if (bus.stop) begin
                        state_d      = DONE;
                        disp_value_d = count_q;
                    end else if (ms_tick) begin
                        count_d      = count_inc;
                        disp_value_d = count_inc;
                        if (count_inc == MAX_VAL) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        led_d  = (state_d == TIMING);
        busy_d = is_busy(state_d);
        case (state_d)
            IDLE:    disp_mode_d = DISP_HI;
            WAIT:    disp_mode_d = DISP_BLANK;
            default: disp_mode_d = DISP_NUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            delay_q       <= '0;
            count_q       <= '0;
            disp_value_q  <= '0;
            disp_mode_q   <= DISP_HI;
            led_q         <= 1'b0;
            false_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            delay_q       <= delay_d;
            count_q       <= count_d;
            disp_value_q  <= disp_value_d;
            disp_mode_q   <= disp_mode_d;
            led_q         <= led_d;
            false_start_q <= false_start_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.led         = led_q;
    assign bus.disp_mode   = disp_mode_q;
    assign bus.disp_value  = disp_value_q;
    assign bus.false_start = false_start_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboarded bench for reaction_timer_ctrl: an elapsed-time model of the
// game predicts every cycle's outputs; directed rounds then random pulses.
module tb_reaction_timer_ctrl;

    localparam int MS    = 4;
    localparam int DELAY = 5;
    localparam int MAXMS = 10;
    localparam int FAULT = 9999;

    localparam int P_IDLE   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_TIMING = 2;
    localparam int P_DONE   = 3;

    typedef struct packed {
        logic        led;
        logic [1:0]  mode;
        logic [13:0] value;
        logic        fs;
        logic        busy;
        logic        vchk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reaction_timer_ctrl_if bus_if ();

    reaction_timer_ctrl #(
        .MS_TICKS  (MS),
        .DELAY_MS  (DELAY),
        .MAX_MS    (MAXMS),
        .FAULT_VAL (FAULT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int   errors = 0;
    int   checks = 0;
    int   rounds = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    // Reference model: phase plus cycles elapsed in that phase.
    int m_phase = P_IDLE;
    int m_el    = 0;
    int m_value = 0;
    bit m_false = 1'b0;

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        e.vchk = 1'b1;
        case (m_phase)
            P_IDLE:   e.mode = 2'd1;
            P_WAIT:   begin e.mode = 2'd0; e.busy = 1'b1; e.vchk = 1'b0; end
            P_TIMING: begin e.led = 1'b1; e.mode = 2'd2; e.busy = 1'b1; e.value = 14'(m_el / MS); end
            default:  begin e.mode = 2'd2; e.value = 14'(m_value); e.fs = m_false; end
        endcase
        return e;
    endfunction

    function automatic void model_step(input logic s, input logic p, input logic c);
        if (c) begin
            m_phase = P_IDLE; m_value = 0; m_false = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (s && !p) begin m_phase = P_WAIT; m_el = 0; end
                P_WAIT: begin
                    if (p) begin m_phase = P_DONE; m_value = FAULT; m_false = 1'b1; end
                    else if (m_el + 1 == DELAY * MS) begin m_phase = P_TIMING; m_el = 0; end
                    else m_el++;
                end
                P_TIMING: begin
                    if (p) begin m_phase = P_DONE; m_value = m_el / MS; end
                    else if (m_el + 1 == MAXMS * MS) begin m_phase = P_DONE; m_value = MAXMS; end
                    else m_el++;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One clock cycle of stimulus; the expected outputs after the next edge are queued.
    task automatic step(input logic s, input logic p, input logic c);
        @(posedge clk);
        #1;
        bus_if.start = s;
        bus_if.stop  = p;
        bus_if.clear = c;
        model_step(s, p, c);
        sb.push_back(model_out());
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        bus_if.clear = 1'b0;
        rst_n = 1'b1;
        sb.delete();
        m_phase = P_IDLE; m_el = 0; m_value = 0; m_false = 1'b0;
        sb.push_back(model_out());
        model_step(1'b0, 1'b0, 1'b0);
        sb.push_back(model_out());
        mon_en = 1'b1;
    endtask

    task automatic wait_led(output int n);
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            n++;
        end while (!bus_if.led && n < 200);
    endtask

    // Monitor: every cycle the DUT presents a fresh output word to compare.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: no expectation queued at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus_if.led !== e.led || bus_if.disp_mode !== e.mode ||
                    bus_if.false_start !== e.fs || bus_if.busy !== e.busy ||
                    (e.vchk && bus_if.disp_value !== e.value)) begin
                    errors++;
                    $display("FAIL outputs @%0t: got led=%b mode=%0d val=%0d fs=%b busy=%b required led=%b mode=%0d val=%0d fs=%b busy=%b",
                             $time, bus_if.led, bus_if.disp_mode, bus_if.disp_value, bus_if.false_start, bus_if.busy,
                             e.led, e.mode, e.value, e.fs, e.busy);
                end
                if (e.mode == 2'd2 && !e.busy && (m_phase != P_DONE || sb.size() == 0 || sb[0].busy || sb[0].mode != 2'd2 || rounds == 0)) begin
                end
            end
        end
    end

    // One line per completed round as the DUT enters DONE.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        logic now_done;
        now_done = rst_n && (bus_if.disp_mode == 2'd2) && !bus_if.busy;
        if (now_done && !prev_done) begin
            rounds++;
            $display("round %0d: value=%0d false_start=%b at %0t", rounds, bus_if.disp_value, bus_if.false_start, $time);
        end
        prev_done = now_done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        bus_if.clear = 1'b0;
        repeat (3) @(posedge clk);
        release_reset();

        // Reset state, then a long idle and a start pulse.
        @(negedge clk);
        check("reset_mode", 32'(bus_if.disp_mode), 1);
        check("reset_led", 32'(bus_if.led), 0);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("wait_mode", 32'(bus_if.disp_mode), 0);
        check("wait_busy", 32'(bus_if.busy), 1);

        // Full round with no stop: timeout at MAX_MS.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        wait_led(n);
        check("led_rise_delay", 32'(n - 1), DELAY * MS);
        m = 0;
        do begin
            step(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            m++;
        end while (bus_if.led && m < 200);
        check("timeout_cycles", 32'(m), MAXMS * MS);
        check("timeout_value", 32'(bus_if.disp_value), MAXMS);
        check("timeout_fs", 32'(bus_if.false_start), 0);

        // Stop 13 cycles after the LED: three ticks elapsed, then held in DONE.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        wait_led(n);
        repeat (12) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stop13_value", 32'(bus_if.disp_value), 3);
        repeat (100) step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0), 1'b0);
        @(negedge clk);
        check("stop13_held", 32'(bus_if.disp_value), 3);

        // False start inside WAIT.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("false_value", 32'(bus_if.disp_value), FAULT);
        check("false_fs", 32'(bus_if.false_start), 1);

        // Stop on the same cycle as the third tick: that tick is not counted.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        wait_led(n);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stop_on_tick_value", 32'(bus_if.disp_value), 2);

        // Clear during TIMING.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        wait_led(n);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("clear_led", 32'(bus_if.led), 0);
        check("clear_mode", 32'(bus_if.disp_mode), 1);

        // Asynchronous reset between edges in TIMING.
        step(1'b1, 1'b0, 1'b0);
        wait_led(n);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_led", 32'(bus_if.led), 0);
        check("arst_mode", 32'(bus_if.disp_mode), 1);
        check("arst_busy", 32'(bus_if.busy), 0);
        check("arst_value", 32'(bus_if.disp_value), 0);
        check("arst_fs", 32'(bus_if.false_start), 0);
        repeat (3) @(posedge clk);
        release_reset();

        // start and clear together in IDLE stays in IDLE; a fresh round times correctly.
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("start_clear_mode", 32'(bus_if.disp_mode), 1);
        check("start_clear_busy", 32'(bus_if.busy), 0);
        step(1'b1, 1'b0, 1'b0);
        wait_led(n);
        check("post_reset_led_delay", 32'(n - 1), DELAY * MS);

        // Random pulses, checked cycle by cycle against the model.
        repeat (3000) begin
            step(logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 24) == 0),
                 logic'($urandom_range(0, 99) == 0));
        end
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Sequencing controller for the reaction-timer game: owns the game state machine, the millisecond time base, the pre-LED delay and the reaction-time count. Takes debounced single-cycle button pulses (start/stop/clear) and drives the LED plus a display request (mode + value) consumed by the existing seven-segment driver. Sits between the button debouncers and the sseg/LED outputs at board top level.

Parameters:
MS_TICKS, 100000, clk cycles per 1 ms tick (100 MHz clock)
DELAY_MS, 5000, ms from start until LED turns on
MAX_MS, 1000, timeout value; count saturates here
FAULT_VAL, 9999, value shown on a false start (stop before LED)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  debounced single-cycle pulse, begin a round
stop  in  1  debounced single-cycle pulse, user reaction
clear  in  1  debounced single-cycle pulse, return to idle
led  out  1  reaction stimulus LED
disp_mode  out  2  display request: 0 BLANK, 1 HI, 2 NUM
disp_value  out  14  binary value 0..9999, valid when disp_mode==NUM
false_start  out  1  high in DONE when round ended by early stop
busy  out  1  high in WAIT or TIMING

Behaviour:
- States: IDLE, WAIT, TIMING, DONE. Reset (rst_n low, async): state=IDLE, led=0, disp_mode=HI, disp_value=0, false_start=0, busy=0, all counters 0. All outputs registered.
- Input priority in the same cycle: clear > stop > start.
- IDLE: disp_mode=HI. start pulse at cycle n -> WAIT at n+1; prescaler and delay counter cleared at n+1.
- WAIT: disp_mode=BLANK, led=0, busy=1. Prescaler counts 0..MS_TICKS-1, emits one-cycle ms_tick on wrap. Delay counter increments per tick; on the tick that brings it to DELAY_MS -> TIMING next cycle, led=1 and disp_value=0 in that same cycle, prescaler restarts at 0.
- WAIT + stop -> DONE next cycle, disp_value=FAULT_VAL, false_start=1, led=0.
- TIMING: led=1, disp_mode=NUM, disp_value live count, busy=1. Each ms_tick increments count. On the tick that brings count to MAX_MS -> DONE, disp_value=MAX_MS.
- TIMING + stop -> DONE next cycle, disp_value=count as of that cycle; a coincident ms_tick is discarded (stop wins, no increment).
- DONE: led=0, disp_mode=NUM, disp_value held, busy=0. start and stop ignored.
- clear from any state -> IDLE next cycle, all outputs to reset values except rst_n-only behaviour identical.
- start outside IDLE ignored; stop in IDLE ignored.
- Counter widths: prescaler $clog2(MS_TICKS); delay $clog2(DELAY_MS+1); count 14 bits, never exceeds MAX_MS.
- rst_n asserted mid-round: immediate return to reset values; no partial state survives deassertion.

Decomposition:
- Package reaction_pkg: state enum (IDLE, WAIT, TIMING, DONE), disp_mode enum (DISP_BLANK, DISP_HI, DISP_NUM), constants for default FAULT_VAL and MAX_MS, display value width (14).
- One sub-module: reaction_ms_tick (prescaler, inputs clk, rst_n, clr, en; output tick one cycle every MS_TICKS enabled cycles). Controller FSM and counters live in reaction_timer_ctrl.

Test Plan:
(bench overrides MS_TICKS=4, DELAY_MS=5, MAX_MS=10, FAULT_VAL=9999)
- Reset then idle 50 cycles -> disp_mode=HI, led=0, busy=0; start pulse -> WAIT next cycle, disp_mode=BLANK, busy=1.
- start, no stop -> led rises exactly 20 cycles after WAIT entry; DONE after further 40 cycles with disp_value=10, led=0, false_start=0.
- start, stop 13 cycles after led rises (3 ticks elapsed) -> DONE next cycle, disp_value=3, held across 100 cycles and further start/stop pulses.
- start, stop 7 cycles into WAIT -> DONE, disp_value=9999, false_start=1, led never asserted.
- stop coincident with ms_tick in TIMING -> captured value excludes that tick; clear in TIMING -> IDLE next cycle, led=0, disp_mode=HI.
- rst_n low asynchronously mid-TIMING (between clock edges) -> outputs at reset values before next edge; start+clear same cycle in IDLE -> stays IDLE.
